// File: rtl/grid_ccff_multichain_loader.sv
// Multi-chain configuration loader: streams one bit per chain per beat, checks
// per-chain parity against a trailer beat and optionally verifies by recirculation.

module grid_ccff_lane (
    input  logic prog_clk,
    input  logic pReset,
    input  logic clr,
    input  logic load_acc,
    input  logic tail_acc,
    input  logic cfg_bit,
    input  logic tail_bit,
    output logic load_par,
    output logic tail_par
);
    always_ff @(posedge prog_clk) begin
        if (!pReset || clr) begin
            load_par <= 1'b0;
            tail_par <= 1'b0;
        end else begin
            if (load_acc) load_par <= load_par ^ cfg_bit;
            if (tail_acc) tail_par <= tail_par ^ tail_bit;
        end
    end
endmodule

module grid_ccff_multichain_loader #(
    parameter int NUM_CHAINS = 4,
    parameter int CHAIN_LEN  = 64,
    parameter int VERIFY_EN  = 1
) (
    input  logic                          prog_clk,
    input  logic                          pReset,
    input  logic                          Test_en,
    input  logic                          start,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [NUM_CHAINS-1:0]         cfg_data,
    output logic [NUM_CHAINS-1:0]         ccff_head,
    output logic                          ccff_shift_en,
    input  logic [NUM_CHAINS-1:0]         ccff_tail,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [NUM_CHAINS-1:0]         err_chain,
    output logic [$clog2(CHAIN_LEN+1)-1:0] beat_cnt
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_VERIFY, S_DONE, S_ERR
    } state_t;

    state_t state;

    logic in_load, in_check, in_verify, can_start, go, accept, vfy_acc, last;
    logic [NUM_CHAINS-1:0] load_par, tail_par, mism_chk, mism_vfy;

    assign in_load   = (state == S_LOAD);
    assign in_check  = (state == S_CHECK);
    assign in_verify = (state == S_VERIFY);
    assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign go        = start && !Test_en && can_start;
    assign busy      = in_load || in_check || in_verify;

    assign cfg_ready     = (in_load || in_check) && !Test_en;
    assign ccff_shift_en = !Test_en && ((in_load && cfg_valid) || in_verify);
    assign ccff_head     = in_load ? cfg_data : (in_verify ? ccff_tail : '0);

    assign accept  = in_load && cfg_valid && !Test_en;
    assign vfy_acc = in_verify && !Test_en;
    assign last    = (beat_cnt == CNT_W'(CHAIN_LEN - 1));

    // The final verify cycle folds the current tail bit in combinationally so the
    // decision lands on the same edge as the last recirculating shift.
    assign mism_chk = cfg_data ^ load_par;
    assign mism_vfy = tail_par ^ ccff_tail ^ load_par;

    grid_ccff_lane u_lane [NUM_CHAINS-1:0] (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clr      (go),
        .load_acc (accept),
        .tail_acc (vfy_acc),
        .cfg_bit  (cfg_data),
        .tail_bit (ccff_tail),
        .load_par (load_par),
        .tail_par (tail_par)
    );

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            err       <= 1'b0;
            err_chain <= '0;
            beat_cnt  <= '0;
        end else if (Test_en) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            err       <= 1'b0;
            err_chain <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state     <= S_LOAD;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        err_chain <= '0;
                        beat_cnt  <= '0;
                    end
                end
                S_LOAD: begin
                    if (cfg_valid) begin
                        if (last) begin
                            state    <= S_CHECK;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (cfg_valid) begin
                        if (|mism_chk) begin
                            state     <= S_ERR;
                            err       <= 1'b1;
                            err_chain <= mism_chk;
                        end else if (VERIFY_EN != 0) begin
                            state <= S_VERIFY;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_VERIFY: begin
                    if (last) begin
                        beat_cnt <= '0;
                        if (|mism_vfy) begin
                            state     <= S_ERR;
                            err       <= 1'b1;
                            err_chain <= mism_vfy;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
